// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - runtime-reconfigurable raster timing generator
module video_timing_gen #(
  parameter int CNT_W  = 11,
  parameter int STRB_W = 1
) (
  input  logic             pix_clk,
  input  logic             rst_n,
  input  logic             cfg_load,
  input  logic [CNT_W-1:0] cfg_h_front,
  input  logic [CNT_W-1:0] cfg_h_sync,
  input  logic [CNT_W-1:0] cfg_h_back,
  input  logic [CNT_W-1:0] cfg_h_act,
  input  logic [CNT_W-1:0] cfg_v_front,
  input  logic [CNT_W-1:0] cfg_v_sync,
  input  logic [CNT_W-1:0] cfg_v_back,
  input  logic [CNT_W-1:0] cfg_v_act,
  input  logic             cfg_hs_pol,
  input  logic             cfg_vs_pol,
  output logic             cfg_err,
  output logic             running,
  output logic             hs,
  output logic             vs,
  output logic             active_video,
  output logic             line_start,
  output logic             frame_start,
  output logic [CNT_W-1:0] px_x,
  output logic [CNT_W-1:0] px_y
);

  typedef struct packed {
    logic [CNT_W-1:0] h_front;
    logic [CNT_W-1:0] h_sync;
    logic [CNT_W-1:0] h_back;
    logic [CNT_W-1:0] h_act;
    logic [CNT_W-1:0] v_front;
    logic [CNT_W-1:0] v_sync;
    logic [CNT_W-1:0] v_back;
    logic [CNT_W-1:0] v_act;
    logic             hs_pol;
    logic             vs_pol;
  } timing_t;

  typedef enum logic {IDLE, RUN} state_t;

  // Totals may reach exactly 2**CNT_W; two guard bits keep four-field sums exact.
  localparam logic [CNT_W+1:0] TOT_MAX = {2'b01, {CNT_W{1'b0}}};
  localparam logic [CNT_W+1:0] TOT_ONE = {{(CNT_W+1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  // Polarity shadows come out of reset as active-high.
  localparam timing_t          SH_RST  = {{(8*CNT_W){1'b0}}, 2'b11};
  // Strobes are always a single pix_clk wide whatever STRB_W says.
  localparam logic             STRB_ON = (STRB_W > 0);

  function automatic logic [CNT_W+1:0] zx(input logic [CNT_W-1:0] a);
    return {2'b00, a};
  endfunction

  state_t           state_q, state_d;
  timing_t          cfg_in, sh, pend_cfg;
  logic             pend;
  logic [CNT_W-1:0] h_cnt, v_cnt;

  logic [CNT_W+1:0] cfg_h_tot, cfg_v_tot;
  logic             cfg_ok, load_ok;
  logic [CNT_W+1:0] h_sync_end, h_blk, h_last, v_sync_end, v_blk, v_last;
  logic             h_end, v_end, wrap, hs_raw, vs_raw, de;

  assign cfg_in = {cfg_h_front, cfg_h_sync, cfg_h_back, cfg_h_act,
                   cfg_v_front, cfg_v_sync, cfg_v_back, cfg_v_act,
                   cfg_hs_pol, cfg_vs_pol};

  assign cfg_h_tot = zx(cfg_h_front) + zx(cfg_h_sync) + zx(cfg_h_back) + zx(cfg_h_act);
  assign cfg_v_tot = zx(cfg_v_front) + zx(cfg_v_sync) + zx(cfg_v_back) + zx(cfg_v_act);
  assign cfg_ok    = (cfg_h_front != '0) && (cfg_h_sync != '0) && (cfg_h_back != '0) &&
                     (cfg_h_act != '0) && (cfg_v_front != '0) && (cfg_v_sync != '0) &&
                     (cfg_v_back != '0) && (cfg_v_act != '0) &&
                     (cfg_h_tot <= TOT_MAX) && (cfg_v_tot <= TOT_MAX);
  assign load_ok   = cfg_load && cfg_ok;

  assign h_sync_end = zx(sh.h_front) + zx(sh.h_sync);
  assign h_blk      = h_sync_end + zx(sh.h_back);
  assign h_last     = h_blk + zx(sh.h_act) - TOT_ONE;
  assign v_sync_end = zx(sh.v_front) + zx(sh.v_sync);
  assign v_blk      = v_sync_end + zx(sh.v_back);
  assign v_last     = v_blk + zx(sh.v_act) - TOT_ONE;

  assign h_end  = (zx(h_cnt) == h_last);
  assign v_end  = (zx(v_cnt) == v_last);
  assign wrap   = h_end && v_end;
  assign hs_raw = (zx(h_cnt) >= zx(sh.h_front)) && (zx(h_cnt) < h_sync_end);
  assign vs_raw = (zx(v_cnt) >= zx(sh.v_front)) && (zx(v_cnt) < v_sync_end);
  assign de     = (zx(h_cnt) >= h_blk) && (zx(v_cnt) >= v_blk);

  assign running = (state_q == RUN);

  // State register.
  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: leave IDLE on the first accepted load, then run until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_ok) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Raster counters, active timing shadows and the pending frame-boundary update.
  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      sh       <= SH_RST;
      pend_cfg <= '0;
      pend     <= 1'b0;
    end else if (state_q == IDLE) begin
      if (load_ok) begin
        sh    <= cfg_in;
        h_cnt <= '0;
        v_cnt <= '0;
      end
    end else begin
      if (h_end) begin
        h_cnt <= '0;
        v_cnt <= v_end ? '0 : v_cnt + CNT_ONE;
      end else begin
        h_cnt <= h_cnt + CNT_ONE;
      end
      // Old pending values land at the wrap; a load in the same cycle queues behind them.
      if (wrap && pend) sh <= pend_cfg;
      if (load_ok) begin
        pend_cfg <= cfg_in;
        pend     <= 1'b1;
      end else if (wrap) begin
        pend     <= 1'b0;
      end
    end
  end

  // Registered video outputs, held at their reset values while idle.
  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      hs           <= 1'b0;
      vs           <= 1'b0;
      active_video <= 1'b0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      px_x         <= '0;
      px_y         <= '0;
    end else if (state_q == RUN) begin
      hs           <= hs_raw ~^ sh.hs_pol;
      vs           <= vs_raw ~^ sh.vs_pol;
      active_video <= de;
      line_start   <= STRB_ON && (h_cnt == '0);
      frame_start  <= STRB_ON && (h_cnt == '0) && (v_cnt == '0);
      px_x         <= de ? h_cnt - sh.h_front - sh.h_sync - sh.h_back : '0;
      px_y         <= de ? v_cnt - sh.v_front - sh.v_sync - sh.v_back : '0;
    end else begin
      hs           <= 1'b0;
      vs           <= 1'b0;
      active_video <= 1'b0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      px_x         <= '0;
      px_y         <= '0;
    end
  end

  // Rejected loads pulse cfg_err for one cycle in either state.
  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) cfg_err <= 1'b0;
    else        cfg_err <= cfg_load && !cfg_ok;
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - directed bench for video_timing_gen
module tb_video_timing_gen;
  localparam int CNT_W = 11;

  logic             pix_clk = 1'b0;
  logic             rst_n   = 1'b0;
  logic             cfg_load = 1'b0;
  logic [CNT_W-1:0] cfg_h_front = '0, cfg_h_sync = '0, cfg_h_back = '0, cfg_h_act = '0;
  logic [CNT_W-1:0] cfg_v_front = '0, cfg_v_sync = '0, cfg_v_back = '0, cfg_v_act = '0;
  logic             cfg_hs_pol = 1'b1, cfg_vs_pol = 1'b1;
  logic             cfg_err, running, hs, vs, active_video, line_start, frame_start;
  logic [CNT_W-1:0] px_x, px_y;

  video_timing_gen #(.CNT_W(CNT_W), .STRB_W(1)) dut (
    .pix_clk(pix_clk), .rst_n(rst_n), .cfg_load(cfg_load),
    .cfg_h_front(cfg_h_front), .cfg_h_sync(cfg_h_sync), .cfg_h_back(cfg_h_back),
    .cfg_h_act(cfg_h_act), .cfg_v_front(cfg_v_front), .cfg_v_sync(cfg_v_sync),
    .cfg_v_back(cfg_v_back), .cfg_v_act(cfg_v_act), .cfg_hs_pol(cfg_hs_pol),
    .cfg_vs_pol(cfg_vs_pol), .cfg_err(cfg_err), .running(running), .hs(hs), .vs(vs),
    .active_video(active_video), .line_start(line_start), .frame_start(frame_start),
    .px_x(px_x), .px_y(px_y)
  );

  always #5 pix_clk = ~pix_clk;

  // Config plus hand-computed per-frame expectations.
  typedef struct {
    int hf, h_sy, hb, ha, vf, v_sy, vb, va, hp, vp;
    int err, frame, lines, active, hs_n, vs_n;
  } vec_t;

  typedef struct {
    int frame, lines, active, hs_n, vs_n, hs_first;
    int first_x, first_y, prev_act, prev_x, prev_y, bad_px;
  } meas_t;

  int    checks = 0;
  int    errors = 0;
  vec_t  tbl[9];
  vec_t  e_cfg;
  meas_t m;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_cfg(input vec_t c);
    cfg_h_front = c.hf[CNT_W-1:0];  cfg_h_sync = c.h_sy[CNT_W-1:0];
    cfg_h_back  = c.hb[CNT_W-1:0];  cfg_h_act  = c.ha[CNT_W-1:0];
    cfg_v_front = c.vf[CNT_W-1:0];  cfg_v_sync = c.v_sy[CNT_W-1:0];
    cfg_v_back  = c.vb[CNT_W-1:0];  cfg_v_act  = c.va[CNT_W-1:0];
    cfg_hs_pol  = c.hp[0];          cfg_vs_pol = c.vp[0];
  endtask

  task automatic do_reset();
    @(negedge pix_clk); rst_n = 1'b0; cfg_load = 1'b0;
    @(negedge pix_clk); rst_n = 1'b1;
  endtask

  // Returns at the negedge right after the sampling posedge.
  task automatic load(input vec_t c);
    @(negedge pix_clk); drive_cfg(c); cfg_load = 1'b1;
    @(negedge pix_clk); cfg_load = 1'b0;
  endtask

  task automatic wait_fs(input int limit);
    int n = 0;
    while (!frame_start && n < limit) begin
      @(negedge pix_clk); n++;
    end
    check("wait_frame_start", int'(frame_start), 1);
  endtask

  // Observe one frame starting at a frame_start cycle, up to the next one.
  task automatic measure(input int hp, input int vp, input int limit, output meas_t r);
    int n = 0;
    r = '{default: 0};
    r.hs_first = -1; r.first_x = -1; r.first_y = -1;
    do begin
      if (line_start) r.lines++;
      if (active_video) begin
        if (r.first_x < 0) begin r.first_x = int'(px_x); r.first_y = int'(px_y); end
        r.active++;
      end else if (px_x != '0 || px_y != '0) begin
        r.bad_px++;
      end
      if (hs == hp[0]) begin
        r.hs_n++;
        if (r.hs_first < 0) r.hs_first = n;
      end
      if (vs == vp[0]) r.vs_n++;
      r.prev_act = int'(active_video); r.prev_x = int'(px_x); r.prev_y = int'(px_y);
      @(negedge pix_clk); n++;
    end while (!frame_start && n < limit);
    r.frame = n;
  endtask

  function automatic int out_bits();
    return int'({running, hs, vs, active_video, line_start, frame_start, cfg_err, px_x, px_y});
  endfunction

  initial begin
    int n, busy;
    //            hf  hsy  hb   ha  vf vsy vb  va  hp vp err frame lines act  hs_n  vs_n
    tbl[0] = '{   2,   3,   4,   8,  1,  2, 1,  4, 1, 1, 0,  136,  8,   32,   24,   34};
    tbl[1] = '{   2,   3,   4,   8,  1,  2, 1,  4, 0, 0, 0,  136,  8,   32,   24,   34};
    tbl[2] = '{   1,   1,   1,   1,  1,  1, 1,  1, 1, 1, 0,   16,  4,    1,    4,    4};
    tbl[3] = '{  98,  63, 110, 640,  1,  1, 1,  2, 1, 1, 0, 4555,  5, 1280,  315,  911};
    tbl[4] = '{  98,  63, 110, 640,  1,  1, 1,  2, 0, 1, 0, 4555,  5, 1280,  315,  911};
    tbl[5] = '{1000,1000,   1,  47,  1,  1, 1,  1, 1, 1, 0, 8192,  4,   47, 4000, 2048};
    tbl[6] = '{   2,   3,   4,   0,  1,  2, 1,  4, 1, 1, 1,    0,  0,    0,    0,    0};
    tbl[7] = '{1000,1000,   1,  48,  1,  1, 1,  1, 1, 1, 1,    0,  0,    0,    0,    0};
    tbl[8] = '{   1,   1,   1,   1,2047,2047,2047,2047,1,1,1,   0,  0,    0,    0,    0};
    e_cfg  = '{   1,   1,   1,   2,  1,  1, 1,  2, 1, 1, 0,   25,  5,    4,    5,    5};

    #12;
    check("reset_outputs", out_bits(), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      do_reset();
      load(tbl[i]);
      check($sformatf("v%0d_cfg_err", i), int'(cfg_err), tbl[i].err);
      check($sformatf("v%0d_running", i), int'(running), 1 - tbl[i].err);
      @(negedge pix_clk);
      check($sformatf("v%0d_err_pulse", i), int'(cfg_err), 0);
      if (tbl[i].err == 0) begin
        wait_fs(20);
        measure(tbl[i].hp, tbl[i].vp, 20000, m);
        check($sformatf("v%0d_frame", i), m.frame, tbl[i].frame);
        check($sformatf("v%0d_lines", i), m.lines, tbl[i].lines);
        check($sformatf("v%0d_active", i), m.active, tbl[i].active);
        check($sformatf("v%0d_hs", i), m.hs_n, tbl[i].hs_n);
        check($sformatf("v%0d_vs", i), m.vs_n, tbl[i].vs_n);
        check($sformatf("v%0d_hs_first", i), m.hs_first, tbl[i].hf);
        check($sformatf("v%0d_first_px", i), m.first_x * 4096 + m.first_y, 0);
        check($sformatf("v%0d_last_act", i), m.prev_act, 1);
        check($sformatf("v%0d_last_px", i), m.prev_x * 4096 + m.prev_y,
              (tbl[i].ha - 1) * 4096 + (tbl[i].va - 1));
        check($sformatf("v%0d_px_idle", i), m.bad_px, 0);
      end else begin
        busy = 0;
        repeat (20) begin
          @(negedge pix_clk);
          if (running || hs || vs || line_start || frame_start) busy++;
        end
        check($sformatf("v%0d_idle_quiet", i), busy, 0);
      end
    end

    // Mid-frame load, then another load exactly on the wrap cycle.
    do_reset();
    load(tbl[0]);
    wait_fs(20);
    n = 0;
    do begin
      cfg_load = 1'b0;
      if (n == 10)  begin drive_cfg(tbl[2]); cfg_load = 1'b1; end
      if (n == 134) begin drive_cfg(e_cfg);  cfg_load = 1'b1; end
      @(negedge pix_clk); n++;
    end while (!frame_start && n < 300);
    cfg_load = 1'b0;
    check("reload_cur_frame", n, 136);
    measure(1, 1, 300, m);
    check("reload_pending_frame", m.frame, 16);
    check("reload_pending_lines", m.lines, 4);
    measure(1, 1, 300, m);
    check("reload_wrap_frame", m.frame, 25);
    check("reload_wrap_lines", m.lines, 5);

    // Several loads in one frame: last accepted one wins, rejected one is ignored.
    n = 0;
    do begin
      if (n == 8) check("run_cfg_err", int'(cfg_err), 1);
      cfg_load = 1'b0;
      if (n == 3) begin drive_cfg(tbl[0]); cfg_load = 1'b1; end
      if (n == 5) begin drive_cfg(tbl[2]); cfg_load = 1'b1; end
      if (n == 7) begin drive_cfg(tbl[6]); cfg_load = 1'b1; end
      @(negedge pix_clk); n++;
    end while (!frame_start && n < 300);
    cfg_load = 1'b0;
    check("multi_cur_frame", n, 25);
    measure(1, 1, 300, m);
    check("multi_last_wins", m.frame, 16);

    // Asynchronous reset in the middle of a line with inverted polarities.
    do_reset();
    load(tbl[1]);
    wait_fs(20);
    repeat (30) @(negedge pix_clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", out_bits(), 0);
    @(negedge pix_clk); rst_n = 1'b1;
    busy = 0;
    repeat (40) begin
      @(negedge pix_clk);
      if (running || hs || vs || active_video || line_start || frame_start) busy++;
    end
    check("post_reset_idle", busy, 0);
    load(tbl[2]);
    check("restart_running", int'(running), 1);
    wait_fs(20);
    measure(1, 1, 300, m);
    check("restart_frame", m.frame, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
